// File: rtl/qspi_seq_arbiter.sv
// Shares the single QSPI sequencer between AHB XIP reads and register-block indirect commands.
// The winner's descriptor is latched, a start pulse is sent, and synchronized busy is tracked to completion or timeout.
module qspi_seq_arbiter #(
    parameter int         LEN_W      = 8,
    parameter logic [7:0] XIP_CMD    = 8'hEB,
    parameter int         XIP_LEN    = 4,
    parameter int         STARVE_LIM = 4,
    parameter int         START_TO   = 16
) (
    input  logic             h_clk,
    input  logic             h_rst,
    input  logic             xip_req_in,
    input  logic [31:0]      xip_addr_in,
    output logic             xip_done_out,
    input  logic             ind_req_in,
    input  logic [7:0]       ind_cmd_in,
    input  logic [31:0]      ind_addr_in,
    input  logic [LEN_W-1:0] ind_len_in,
    output logic             ind_done_out,
    input  logic             qspi_busy_in,
    output logic             start_seq_out,
    output logic             seq_is_xip_out,
    output logic [7:0]       seq_cmd_out,
    output logic [31:0]      seq_addr_out,
    output logic [LEN_W-1:0] seq_len_out,
    output logic             grant_xip_out,
    output logic             grant_ind_out,
    output logic             timeout_err_out
);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int TW = $clog2(START_TO + 1);

    typedef struct packed {
        logic             is_xip;
        logic [7:0]       cmd;
        logic [31:0]      addr;
        logic [LEN_W-1:0] len;
    } seq_desc_t;

    typedef enum logic [2:0] {IDLE, ARB, START, WAIT_BUSY, RUN, DONE, ERR} state_t;

    state_t    state;
    seq_desc_t desc;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tcnt;
    logic          busy_meta, busy_s;
    logic          ind_wins;

    assign {seq_is_xip_out, seq_cmd_out, seq_addr_out, seq_len_out} = desc;

    // XIP has priority unless the indirect side has been passed over STARVE_LIM times in a row
    assign ind_wins = ind_req_in && (!xip_req_in || starve_cnt == SW'(STARVE_LIM));

    always_ff @(posedge h_clk or posedge h_rst) begin
        if (h_rst) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= qspi_busy_in;
            busy_s    <= busy_meta;
        end
    end

    always_ff @(posedge h_clk or posedge h_rst) begin
        if (h_rst) begin
            state           <= IDLE;
            desc            <= '0;
            starve_cnt      <= '0;
            tcnt            <= '0;
            start_seq_out   <= 1'b0;
            grant_xip_out   <= 1'b0;
            grant_ind_out   <= 1'b0;
            xip_done_out    <= 1'b0;
            ind_done_out    <= 1'b0;
            timeout_err_out <= 1'b0;
        end else begin
            start_seq_out   <= 1'b0;
            xip_done_out    <= 1'b0;
            ind_done_out    <= 1'b0;
            timeout_err_out <= 1'b0;
            case (state)
                IDLE: if (xip_req_in || ind_req_in) state <= ARB;
                ARB: begin
                    if (ind_wins) begin
                        desc          <= {1'b0, ind_cmd_in, ind_addr_in, ind_len_in};
                        grant_ind_out <= 1'b1;
                        starve_cnt    <= '0;
                        start_seq_out <= 1'b1;
                        state         <= START;
                    end else if (xip_req_in) begin
                        desc          <= {1'b1, XIP_CMD, xip_addr_in, LEN_W'(XIP_LEN)};
                        grant_xip_out <= 1'b1;
                        // below the limit here, so the increment saturates at STARVE_LIM on its own
                        starve_cnt    <= ind_req_in ? starve_cnt + SW'(1) : '0;
                        start_seq_out <= 1'b1;
                        state         <= START;
                    end else begin
                        starve_cnt <= '0;
                        state      <= IDLE;
                    end
                end
                START: begin
                    tcnt  <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy_s) begin
                        state <= RUN;
                    end else if (tcnt == TW'(START_TO - 1)) begin
                        timeout_err_out <= 1'b1;
                        grant_xip_out   <= 1'b0;
                        grant_ind_out   <= 1'b0;
                        state           <= ERR;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RUN: if (!busy_s) begin
                    xip_done_out  <= desc.is_xip;
                    ind_done_out  <= !desc.is_xip;
                    grant_xip_out <= 1'b0;
                    grant_ind_out <= 1'b0;
                    state         <= DONE;
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_seq_arbiter.sv
// Bench for qspi_seq_arbiter: a timeline model predicts every output each cycle from request levels
// and the busy waveform the bench drives; directed scenarios pin latencies and grant order with literals.
module tb_qspi_seq_arbiter;
    localparam int LEN_W = 8;
    localparam int STARVE_LIM = 4;
    localparam int START_TO = 16;

    logic h_clk = 1'b0;
    logic h_rst = 1'b1;
    logic xip_req_in = 1'b0;
    logic [31:0] xip_addr_in = '0;
    logic xip_done_out;
    logic ind_req_in = 1'b0;
    logic [7:0] ind_cmd_in = '0;
    logic [31:0] ind_addr_in = '0;
    logic [LEN_W-1:0] ind_len_in = '0;
    logic ind_done_out;
    logic qspi_busy_in = 1'b0;
    logic start_seq_out, seq_is_xip_out, grant_xip_out, grant_ind_out, timeout_err_out;
    logic [7:0] seq_cmd_out;
    logic [31:0] seq_addr_out;
    logic [LEN_W-1:0] seq_len_out;

    int n_cmp = 0;
    int n_fail = 0;
    int rsp_k = 3;   // busy rises this many cycles after the start pulse
    int rsp_l = 20;  // busy stays high this many cycles; 0 = never rises

    qspi_seq_arbiter dut (
        .h_clk(h_clk), .h_rst(h_rst),
        .xip_req_in(xip_req_in), .xip_addr_in(xip_addr_in), .xip_done_out(xip_done_out),
        .ind_req_in(ind_req_in), .ind_cmd_in(ind_cmd_in), .ind_addr_in(ind_addr_in),
        .ind_len_in(ind_len_in), .ind_done_out(ind_done_out), .qspi_busy_in(qspi_busy_in),
        .start_seq_out(start_seq_out), .seq_is_xip_out(seq_is_xip_out), .seq_cmd_out(seq_cmd_out),
        .seq_addr_out(seq_addr_out), .seq_len_out(seq_len_out), .grant_xip_out(grant_xip_out),
        .grant_ind_out(grant_ind_out), .timeout_err_out(timeout_err_out)
    );

    always #5 h_clk = ~h_clk;

    // qspi_cont stand-in: busy pulse relative to each start
    initial begin
        forever begin
            @(negedge h_clk);
            if (start_seq_out && rsp_l > 0) begin
                repeat (rsp_k) @(negedge h_clk);
                qspi_busy_in = 1'b1;
                repeat (rsp_l) @(negedge h_clk);
                qspi_busy_in = 1'b0;
            end
        end
    end

    // Timeline model and per-cycle compare
    logic [54:0] act, expv;
    initial begin
        int cyc, phase, starve, exp_start, exp_end, w, f;
        logic m_x, m_err, e_start, in_seq, at_end;
        logic [7:0] m_cmd;
        logic [31:0] m_addr;
        logic [7:0] m_len;
        cyc = 0; phase = 0; starve = 0; exp_start = 0; exp_end = 0;
        m_x = 0; m_err = 0; m_cmd = 0; m_addr = 0; m_len = 0;
        forever begin
            @(negedge h_clk);
            cyc++;
            if (h_rst) begin
                phase = 0; starve = 0; m_x = 0; m_err = 0; m_cmd = 0; m_addr = 0; m_len = 0;
            end
            e_start = (phase == 2 && cyc == exp_start);
            in_seq  = (phase == 2 && cyc >= exp_start && cyc < exp_end);
            at_end  = (phase == 2 && cyc == exp_end);
            expv = {e_start, m_x, m_cmd, m_addr, m_len, in_seq && m_x, in_seq && !m_x,
                    at_end && !m_err && m_x, at_end && !m_err && !m_x, at_end && m_err};
            act  = {start_seq_out, seq_is_xip_out, seq_cmd_out, seq_addr_out, seq_len_out, grant_xip_out,
                    grant_ind_out, xip_done_out, ind_done_out, timeout_err_out};
            n_cmp++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL cycle_outputs cyc=%0d got=%h want=%h", cyc, act, expv);
            end
            if (!h_rst) begin
                case (phase)
                    0: if (xip_req_in || ind_req_in) phase = 1;
                    1: begin
                        if (!(xip_req_in || ind_req_in)) begin
                            phase = 0; starve = 0;
                        end else begin
                            if (xip_req_in && !(ind_req_in && starve == STARVE_LIM)) begin
                                m_x = 1; m_cmd = 8'hEB; m_addr = xip_addr_in; m_len = 8'd4;
                                starve = ind_req_in ? ((starve < STARVE_LIM) ? starve + 1 : STARVE_LIM) : 0;
                            end else begin
                                m_x = 0; m_cmd = ind_cmd_in; m_addr = ind_addr_in; m_len = ind_len_in;
                                starve = 0;
                            end
                            exp_start = cyc + 1;
                            w = rsp_k + 2;               // busy_s visible, relative to start
                            if (rsp_l == 0 || w > START_TO) begin
                                m_err = 1; exp_end = exp_start + START_TO + 1;
                            end else begin
                                m_err = 0; f = rsp_k + rsp_l + 2;  // busy_s back low
                                exp_end = exp_start + ((w + 1 > f) ? w + 1 : f) + 1;
                            end
                            phase = 2;
                        end
                    end
                    default: if (cyc == exp_end) phase = 0;
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic wait_start(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge h_clk);
            if (start_seq_out) begin n = i; break; end
        end
        if (n < 0) begin n_cmp++; n_fail++; $display("FAIL wait_start no start pulse within 100 cycles"); end
    endtask

    task automatic wait_end(output int n, output logic [2:0] kind);
        n = -1; kind = 3'b000;
        for (int i = 1; i <= 100; i++) begin
            @(negedge h_clk);
            if (xip_done_out || ind_done_out || timeout_err_out) begin
                n = i; kind = {xip_done_out, ind_done_out, timeout_err_out}; break;
            end
        end
        if (n < 0) begin n_cmp++; n_fail++; $display("FAIL wait_end no completion within 100 cycles"); end
    endtask

    initial begin
        int n, pulses;
        logic [2:0] kind;
        logic [9:0] pat;
        repeat (3) @(negedge h_clk);
        chk("reset_outputs", {start_seq_out, seq_is_xip_out, seq_cmd_out, seq_addr_out, seq_len_out,
            grant_xip_out, grant_ind_out, xip_done_out, ind_done_out, timeout_err_out}, 64'd0);
        @(posedge h_clk); #1 h_rst = 1'b0;
        repeat (3) @(posedge h_clk);

        // XIP only
        #1 rsp_k = 3; rsp_l = 20; xip_addr_in = 32'h0000_1000; xip_req_in = 1'b1;
        wait_start(n);
        chk("xip_cmd", seq_cmd_out, 8'hEB);
        chk("xip_len", seq_len_out, 4);
        chk("xip_owner", seq_is_xip_out, 1);
        wait_end(n, kind);
        chk("xip_latency", n, 26);
        chk("xip_kind", kind, 3'b100);
        @(posedge h_clk); #1 xip_req_in = 1'b0;
        repeat (4) @(posedge h_clk);

        // Indirect only
        #1 rsp_k = 2; rsp_l = 10; ind_cmd_in = 8'h06; ind_addr_in = 0; ind_len_in = 0; ind_req_in = 1'b1;
        wait_start(n);
        chk("ind_owner", seq_is_xip_out, 0);
        chk("ind_cmd", seq_cmd_out, 8'h06);
        chk("ind_grant", grant_ind_out, 1);
        wait_end(n, kind);
        chk("ind_latency", n, 15);
        chk("ind_kind", kind, 3'b010);
        @(posedge h_clk); #1 ind_req_in = 1'b0;
        repeat (4) @(posedge h_clk);

        // Starvation: both held
        #1 rsp_k = 1; rsp_l = 2; xip_addr_in = 32'h0000_3000;
        ind_cmd_in = 8'h9F; ind_addr_in = 32'h40; ind_len_in = 8; xip_req_in = 1'b1; ind_req_in = 1'b1;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            wait_start(n);
            pat = {pat[8:0], seq_is_xip_out};
            wait_end(n, kind);
            chk("starve_latency", n, 6);
        end
        chk("starve_pattern", pat, 10'b1111011110);
        @(posedge h_clk); #1 xip_req_in = 1'b0; ind_req_in = 1'b0;
        repeat (4) @(posedge h_clk);

        // Timeout, then a fresh request is accepted
        #1 rsp_l = 0; ind_cmd_in = 8'h05; ind_req_in = 1'b1;
        wait_start(n);
        wait_end(n, kind);
        chk("timeout_latency", n, 17);
        chk("timeout_kind", kind, 3'b001);
        @(posedge h_clk); #1 ind_req_in = 1'b0; rsp_k = 1; rsp_l = 2; xip_req_in = 1'b1;
        wait_start(n);
        wait_end(n, kind);
        chk("post_timeout_latency", n, 6);
        chk("post_timeout_kind", kind, 3'b100);
        @(posedge h_clk); #1 xip_req_in = 1'b0;
        repeat (4) @(posedge h_clk);

        // Request dropped and address changed during RUN
        #1 rsp_k = 3; rsp_l = 20; xip_addr_in = 32'h0000_5550; xip_req_in = 1'b1;
        wait_start(n);
        repeat (8) @(posedge h_clk);
        #1 xip_req_in = 1'b0; xip_addr_in = 32'hDEAD_0000;
        wait_end(n, kind);
        chk("midchg_latency", 7 + n, 26);
        chk("midchg_kind", kind, 3'b100);
        chk("midchg_addr", seq_addr_out, 32'h0000_5550);
        repeat (5) @(posedge h_clk);

        // Reset in the middle of RUN
        #1 xip_addr_in = 32'h0000_7000; xip_req_in = 1'b1;
        wait_start(n);
        repeat (8) @(posedge h_clk);
        #1 h_rst = 1'b1; xip_req_in = 1'b0;
        @(negedge h_clk);
        chk("midrun_reset_outputs", {start_seq_out, seq_is_xip_out, seq_cmd_out, seq_addr_out, seq_len_out,
            grant_xip_out, grant_ind_out, xip_done_out, ind_done_out, timeout_err_out}, 64'd0);
        repeat (2) @(posedge h_clk);
        #1 h_rst = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge h_clk);
            if (start_seq_out || xip_done_out || ind_done_out || timeout_err_out) pulses++;
        end
        chk("post_reset_pulses", pulses, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/qspi_seq_arbiter.md
Name: qspi_seq_arbiter

Overview:
Sits between the AHB slave controller and qspi_cont, and shares the single QSPI sequencer between two requesters: XIP reads from AHB and indirect commands from the register block. Grants one requester and latches its descriptor (cmd, addr, length). Pulses the sequence start, then tracks qspi_busy through start and completion. Returns a done pulse to the winner and flags sequences that never start.

Parameters:
LEN_W, 8, width of transfer byte-length field
XIP_CMD, 8'hEB, opcode issued for XIP reads
XIP_LEN, 4, byte length of every XIP read
STARVE_LIM, 4, consecutive XIP grants allowed while indirect request pending
START_TO, 16, h_clk cycles to wait for synchronized busy to rise after start

Ports:
h_clk  in  1  system clock
h_rst  in  1  asynchronous reset, active-high
xip_req_in  in  1  XIP request level, held until xip_done_out
xip_addr_in  in  32  XIP byte address
xip_done_out  out  1  one-cycle XIP completion pulse
ind_req_in  in  1  indirect request level, held until ind_done_out or timeout_err_out
ind_cmd_in  in  8  indirect opcode
ind_addr_in  in  32  indirect address
ind_len_in  in  LEN_W  indirect byte length
ind_done_out  out  1  one-cycle indirect completion pulse
qspi_busy_in  in  1  qspi_cont busy flag (sclk domain)
start_seq_out  out  1  one-cycle start pulse to qspi_cont
seq_is_xip_out  out  1  latched owner, 1 = XIP
seq_cmd_out  out  8  latched opcode
seq_addr_out  out  32  latched address
seq_len_out  out  LEN_W  latched length
grant_xip_out  out  1  XIP owns the sequencer
grant_ind_out  out  1  indirect owns the sequencer
timeout_err_out  out  1  one-cycle pulse: busy never rose

Behaviour:
- Async active-high reset: state IDLE. All outputs are 0, including seq_* and both grants. Starvation counter, timeout counter and busy synchronizer are cleared.
- Synchronizer: qspi_busy_in passes through a 2-flop synchronizer to give busy_s. busy_s lags qspi_busy_in by 2 h_clk cycles.
- States and transitions:
  - IDLE -> ARB when either request is high.
  - ARB: selects the winner and latches seq_* for it.
    - XIP winner: XIP_CMD, xip_addr_in, XIP_LEN, seq_is_xip_out = 1.
    - Indirect winner: ind_* inputs, seq_is_xip_out = 0.
    - Asserts the matching grant. Goes to START.
  - START: start_seq_out = 1 for exactly one cycle. Goes to WAIT_BUSY. Timeout counter loads 0.
  - WAIT_BUSY: increments the timeout counter each cycle.
    - busy_s = 1 -> RUN.
    - Counter reaches START_TO - 1 with busy_s still 0 -> ERR.
  - RUN: waits for busy_s = 0, then -> DONE.
  - DONE: pulses the owner's done output for 1 cycle. Grant drops. seq_* hold their values. Goes to IDLE.
  - ERR: timeout_err_out pulses for 1 cycle and the grant drops. The owner's done is not pulsed. Goes to IDLE.
- Arbitration rule in ARB:
  - Fixed priority to XIP.
  - Exception: indirect wins when ind_req_in is high and the starvation counter equals STARVE_LIM.
- Starvation counter:
  - Increments on each XIP grant while ind_req_in is high.
  - Clears on an indirect grant, or when ind_req_in is low in ARB.
  - Saturates at STARVE_LIM.
- Request sampling: requests are sampled only in IDLE and ARB. Changes during START/WAIT_BUSY/RUN have no effect. Dropping a request mid-sequence does not abort it.
- Minimum turnaround: start pulse to next start pulse is at least 5 cycles (START, WAIT_BUSY, RUN, DONE, IDLE/ARB), plus busy duration.
- Both requests high in the same ARB cycle: the priority rule decides. The loser stays pending and is granted next unless the priority rule repeats XIP.
- busy_s already 1 on entry to WAIT_BUSY: RUN is entered the next cycle.
- Reset mid-sequence: immediate return to IDLE with all outputs 0. No done or error pulse.
- grant_xip_out and grant_ind_out are never both 1. Neither is 1 outside ARB..DONE.

Test Plan:
- XIP only: xip_req=1, addr=32'h0000_1000, busy rises 3 cycles after start and lasts 20 cycles.
  -> one start_seq_out, seq_cmd=8'hEB, seq_len=4, xip_done_out pulses once; no ind_done_out.
- Indirect only: ind_cmd=8'h06, addr=0, len=0, busy for 10 cycles.
  -> seq_is_xip=0, seq_cmd=8'h06, ind_done_out pulses once, grant_ind_out high from ARB to DONE.
- Starvation with STARVE_LIM=4: xip_req and ind_req held high continuously.
  -> grants follow X,X,X,X,I,X,X,X,X,I; counter clears after each indirect grant.
- Timeout with START_TO=16: ind request issued, busy held 0.
  -> timeout_err_out pulses 17 cycles after start_seq_out, no ind_done_out, state returns to IDLE and accepts a new request.
- Reset mid-RUN: assert h_rst while busy=1.
  -> all outputs 0 the same cycle; after release with no requests, stays IDLE and no pulses appear.
- Mid-sequence change: xip_req dropped and xip_addr changed during RUN.
  -> seq_addr_out holds the original value and xip_done_out still pulses.
